// File: rtl/analisador_quadro_peso_pkg.sv
// analisador_quadro_peso_pkg
// Shared definitions for the weighing-station frame parser: ASCII constants,
// the parser state encoding and small byte-classification helpers.
// When ANALISADOR_CHECKSUM_EN is defined the extra CHECK state is added to
// the state encoding.
package analisador_quadro_peso_pkg;

  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  localparam int ESTADO_W = 3;

  localparam logic [ESTADO_W-1:0] ST_ESPERA      = 3'd0;
  localparam logic [ESTADO_W-1:0] ST_CAMPO_MIN   = 3'd1;
  localparam logic [ESTADO_W-1:0] ST_CAMPO_MAX   = 3'd2;
  localparam logic [ESTADO_W-1:0] ST_CAMPO_ATUAL = 3'd3;
  localparam logic [ESTADO_W-1:0] ST_FIM         = 3'd4;
  localparam logic [ESTADO_W-1:0] ST_CHECK       = 3'd5;

  typedef enum logic [ESTADO_W-1:0] {
    ESPERA      = ST_ESPERA,
    CAMPO_MIN   = ST_CAMPO_MIN,
    CAMPO_MAX   = ST_CAMPO_MAX,
    CAMPO_ATUAL = ST_CAMPO_ATUAL,
    FIM         = ST_FIM
`ifdef ANALISADOR_CHECKSUM_EN
    , CHECK     = ST_CHECK
`endif
  } estado_t;

  function automatic logic eh_digito(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

  // '0'..'9' minus 0x30 always fits in a nibble; the upper bits are dropped.
  function automatic logic [3:0] valor_digito(input logic [7:0] b);
    logic [7:0] d;
    d = b - ASCII_ZERO;
    return d[3:0];
  endfunction

endpackage

// File: rtl/contador_timeout_quadro.sv
// contador_timeout_quadro
// Inter-byte idle counter for byte-oriented protocol parsers.
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high reset
//   zera   - clears the count (takes priority over conta)
//   conta  - counts one idle cycle
//   fim    - high while conta is asserted in the terminal cycle
//            (count == TIMEOUT_CYCLES-1)
// Parameters: TIMEOUT_CYCLES (idle cycles allowed), TW (counter width,
// 2^TW must exceed TIMEOUT_CYCLES).
module contador_timeout_quadro #(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int TW             = 23
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [TW-1:0] TERMINAL = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] contagem;

  // Saturates at the terminal value so a parked counter never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta && (contagem != TERMINAL)) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim = conta && (contagem == TERMINAL);

endmodule

// File: rtl/analisador_quadro_peso.sv
// analisador_quadro_peso
// Frame parser and range checker for the weighing station. Accepts frames of
// the form '#' <min> <max> <current>, each field DIGITS ASCII decimal digits,
// latches the fields as packed BCD and flags whether current lies in
// [min, max].
// Optional build macro: ANALISADOR_CHECKSUM_EN adds a trailing XOR byte
// (XOR of all digit bytes) checked before the frame is accepted.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   rx_valid, rx_byte   - one-cycle byte strobe from the serial receiver
//   peso_min/max/atual  - latched fields, packed BCD, MS digit first
//   pertence_intervalo  - registered peso_min <= peso_atual <= peso_max
//   peso_max_zero       - registered peso_max == 0
//   quadro_ok           - one-cycle pulse, frame accepted and fields updated
//   quadro_erro         - one-cycle pulse, frame aborted
//   ocupado             - high whenever the parser is not in ESPERA
module analisador_quadro_peso
  import analisador_quadro_peso_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int TW             = 23
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  output logic [4*DIGITS-1:0] peso_min,
  output logic [4*DIGITS-1:0] peso_max,
  output logic [4*DIGITS-1:0] peso_atual,
  output logic               pertence_intervalo,
  output logic               peso_max_zero,
  output logic               quadro_ok,
  output logic               quadro_erro,
  output logic               ocupado
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(DIGITS - 1);

  estado_t state, next_state;

  logic [W-1:0]  sh_min, sh_max, sh_atual;
  logic [W-1:0]  min_n, max_n, atual_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          erro_n;
  logic          latch;
  logic          tempo_fim;
  logic          zera_tempo;
  logic          conta_tempo;
  logic          ultimo_digito;
  logic [W-1:0]  nibble_ext;

`ifdef ANALISADOR_CHECKSUM_EN
  logic [7:0] xor_acc, xor_n;
`endif

  assign ocupado       = (state != ESPERA);
  assign ultimo_digito = (cnt == ULTIMO);
  assign nibble_ext    = W'(valor_digito(rx_byte));

  // Any received byte restarts the idle window; outside a frame the counter
  // is held clear so a new frame always starts with a full window.
  assign zera_tempo  = rx_valid || (state == ESPERA);
  assign conta_tempo = ocupado && !rx_valid;

  contador_timeout_quadro #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera_tempo),
    .conta (conta_tempo),
    .fim   (tempo_fim)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ESPERA;
      sh_min   <= '0;
      sh_max   <= '0;
      sh_atual <= '0;
      cnt      <= '0;
`ifdef ANALISADOR_CHECKSUM_EN
      xor_acc  <= '0;
`endif
    end else begin
      state    <= next_state;
      sh_min   <= min_n;
      sh_max   <= max_n;
      sh_atual <= atual_n;
      cnt      <= cnt_n;
`ifdef ANALISADOR_CHECKSUM_EN
      xor_acc  <= xor_n;
`endif
    end
  end

  // latch marks the transition into FIM; the shadow values computed here
  // already include the final byte, so the outputs can be loaded on the same
  // edge and quadro_ok lines up with the new field values.
  always_comb begin
    next_state = state;
    min_n      = sh_min;
    max_n      = sh_max;
    atual_n    = sh_atual;
    cnt_n      = cnt;
    erro_n     = 1'b0;
    latch      = 1'b0;
`ifdef ANALISADOR_CHECKSUM_EN
    xor_n      = xor_acc;
`endif

    case (state)
      ESPERA: begin
        if (rx_valid && (rx_byte == ASCII_HASH)) begin
          next_state = CAMPO_MIN;
          min_n      = '0;
          max_n      = '0;
          atual_n    = '0;
          cnt_n      = '0;
`ifdef ANALISADOR_CHECKSUM_EN
          xor_n      = '0;
`endif
        end
      end

      CAMPO_MIN, CAMPO_MAX, CAMPO_ATUAL
`ifdef ANALISADOR_CHECKSUM_EN
      , CHECK
`endif
      : begin
        if (rx_valid) begin
          if (rx_byte == ASCII_HASH) begin
            // Resync: a fresh start marker restarts the frame silently.
            next_state = CAMPO_MIN;
            min_n      = '0;
            max_n      = '0;
            atual_n    = '0;
            cnt_n      = '0;
`ifdef ANALISADOR_CHECKSUM_EN
            xor_n      = '0;
`endif
          end
`ifdef ANALISADOR_CHECKSUM_EN
          else if (state == CHECK) begin
            if (rx_byte == xor_acc) begin
              next_state = FIM;
              latch      = 1'b1;
            end else begin
              next_state = ESPERA;
              erro_n     = 1'b1;
            end
          end
`endif
          else if (eh_digito(rx_byte)) begin
`ifdef ANALISADOR_CHECKSUM_EN
            xor_n = xor_acc ^ rx_byte;
`endif
            if (state == CAMPO_MIN) begin
              min_n = (sh_min << 4) | nibble_ext;
            end else if (state == CAMPO_MAX) begin
              max_n = (sh_max << 4) | nibble_ext;
            end else begin
              atual_n = (sh_atual << 4) | nibble_ext;
            end

            if (ultimo_digito) begin
              cnt_n = '0;
              if (state == CAMPO_MIN) begin
                next_state = CAMPO_MAX;
              end else if (state == CAMPO_MAX) begin
                next_state = CAMPO_ATUAL;
              end else begin
`ifdef ANALISADOR_CHECKSUM_EN
                next_state = CHECK;
`else
                next_state = FIM;
                latch      = 1'b1;
`endif
              end
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else begin
            next_state = ESPERA;
            erro_n     = 1'b1;
          end
        end else if (tempo_fim) begin
          next_state = ESPERA;
          erro_n     = 1'b1;
        end
      end

      FIM: begin
        next_state = ESPERA;
      end

      default: begin
        next_state = ESPERA;
      end
    endcase
  end

  // Fields change only on an accepted frame. The range flags are refreshed
  // in the cycle quadro_ok is high, so they stay 0 until the first frame and
  // always describe the currently latched fields.
  always_ff @(posedge clock) begin
    if (reset) begin
      peso_min           <= '0;
      peso_max           <= '0;
      peso_atual         <= '0;
      pertence_intervalo <= 1'b0;
      peso_max_zero      <= 1'b0;
      quadro_ok          <= 1'b0;
      quadro_erro        <= 1'b0;
    end else begin
      quadro_ok   <= latch;
      quadro_erro <= erro_n;
      if (latch) begin
        peso_min   <= min_n;
        peso_max   <= max_n;
        peso_atual <= atual_n;
      end
      if (quadro_ok) begin
        pertence_intervalo <= (peso_min <= peso_atual) && (peso_atual <= peso_max);
        peso_max_zero      <= (peso_max == '0);
      end
    end
  end

endmodule

// File: tb/tb_analisador_quadro_peso.sv
// tb_analisador_quadro_peso
// Directed bench for analisador_quadro_peso with DIGITS=4, TIMEOUT_CYCLES=20.
// Expected frames go into a scoreboard queue as they are sent; a monitor pops
// and compares them whenever quadro_ok pulses. Follows ANALISADOR_CHECKSUM_EN
// by appending the XOR byte to every frame when the macro is defined.
module tb_analisador_quadro_peso;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [15:0] peso_min, peso_max, peso_atual;
  logic        pertence_intervalo, peso_max_zero;
  logic        quadro_ok, quadro_erro, ocupado;

  typedef struct {
    logic [15:0] mn;
    logic [15:0] mx;
    logic [15:0] at;
    logic        pert;
    logic        zero;
  } esperado_t;

  esperado_t sb[$];
  esperado_t pend_e;
  logic      pend = 1'b0;

  int checks = 0;
  int errors = 0;
  int ok_count = 0;
  int erro_count = 0;
  int exp_ok = 0;
  int exp_err = 0;

  analisador_quadro_peso #(
    .DIGITS         (4),
    .TIMEOUT_CYCLES (20),
    .TW             (5)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .rx_valid           (rx_valid),
    .rx_byte            (rx_byte),
    .peso_min           (peso_min),
    .peso_max           (peso_max),
    .peso_atual         (peso_atual),
    .pertence_intervalo (pertence_intervalo),
    .peso_max_zero      (peso_max_zero),
    .quadro_ok          (quadro_ok),
    .quadro_erro        (quadro_erro),
    .ocupado            (ocupado)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] bcdOf(input string d, input int off);
    logic [15:0] r;
    logic [7:0]  c;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      c = d[off + i];
      r = {r[11:0], c[3:0]};
    end
    return r;
  endfunction

  function automatic int decOf(input string d, input int off);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) r = r * 10 + (int'(d[off + i]) - 48);
    return r;
  endfunction

  function automatic logic [7:0] xorOf(input string d);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < d.len(); i++) x = x ^ d[i];
    return x;
  endfunction

  task automatic pushExpected(input string d);
    esperado_t e;
    e.mn   = bcdOf(d, 0);
    e.mx   = bcdOf(d, 4);
    e.at   = bcdOf(d, 8);
    e.pert = (decOf(d, 0) <= decOf(d, 8)) && (decOf(d, 8) <= decOf(d, 4));
    e.zero = (decOf(d, 4) == 0);
    sb.push_back(e);
    exp_ok++;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // rx_valid is high across exactly one rising edge; returns on the falling
  // edge right after that edge.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) begin
      sendByte(s[i]);
      idleCycles(2);
    end
  endtask

  task automatic sendChecksum(input string d);
`ifdef ANALISADOR_CHECKSUM_EN
    sendByte(xorOf(d));
    idleCycles(2);
`else
    if (d.len() == 0) idleCycles(1);
`endif
  endtask

  task automatic sendFrame(input string d);
    pushExpected(d);
    applyStimulus({"#", d});
    sendChecksum(d);
    idleCycles(3);
  endtask

  always @(negedge clock) begin
    if (pend) begin
      checkOutput("pertence_intervalo", pertence_intervalo, pend_e.pert);
      checkOutput("peso_max_zero", peso_max_zero, pend_e.zero);
      pend = 1'b0;
    end
    if (quadro_ok === 1'b1 || quadro_erro === 1'b1)
      checkOutput("pulso_unico", quadro_ok & quadro_erro, 0);
    if (quadro_ok === 1'b1) begin
      ok_count++;
      checkOutput("ok_esperado", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        pend_e = sb.pop_front();
        checkOutput("peso_min", peso_min, pend_e.mn);
        checkOutput("peso_max", peso_max, pend_e.mx);
        checkOutput("peso_atual", peso_atual, pend_e.at);
        pend = 1'b1;
      end
    end
    if (quadro_erro === 1'b1) erro_count++;
  end

  initial begin
    // Reset state
    reset = 1'b1;
    idleCycles(3);
    checkOutput("rst_peso_min", peso_min, 0);
    checkOutput("rst_peso_max", peso_max, 0);
    checkOutput("rst_peso_atual", peso_atual, 0);
    checkOutput("rst_quadro_ok", quadro_ok, 0);
    checkOutput("rst_quadro_erro", quadro_erro, 0);
    checkOutput("rst_ocupado", ocupado, 0);
    reset = 1'b0;
    idleCycles(2);
    checkOutput("rst_pertence", pertence_intervalo, 0);
    checkOutput("rst_max_zero", peso_max_zero, 0);
    checkOutput("rst_ocupado_pos", ocupado, 0);

    // Main frame and range boundaries
    sendFrame("010005000250");
    checkOutput("ok_count_main", ok_count, exp_ok);
    sendFrame("010005000500");
    sendFrame("010005000100");
    sendFrame("010005000501");
    sendFrame("000000000000");
    sendFrame("050001000300");
    checkOutput("ok_count_bound", ok_count, exp_ok);
    checkOutput("erro_count_bound", erro_count, exp_err);

    // Non-digit inside a field aborts and keeps the previous fields
    applyStimulus("#0100A");
    exp_err++;
    idleCycles(3);
    checkOutput("erro_count_abort", erro_count, exp_err);
    checkOutput("ok_count_abort", ok_count, exp_ok);
    checkOutput("ocupado_abort", ocupado, 0);
    checkOutput("keep_peso_min", peso_min, 16'h0500);
    checkOutput("keep_peso_max", peso_max, 16'h0100);
    checkOutput("keep_peso_atual", peso_atual, 16'h0300);

    // '#' mid-frame restarts without error
    applyStimulus("#0100050");
    sendFrame("010002000150");
    checkOutput("erro_count_resync", erro_count, exp_err);
    checkOutput("ok_count_resync", ok_count, exp_ok);

    // Timeout: error on the 20th idle edge after the last byte
    applyStimulus("#0");
    sendByte("1");
    idleCycles(19);
    checkOutput("timeout_cedo_erro", quadro_erro, 0);
    checkOutput("timeout_cedo_ocupado", ocupado, 1);
    idleCycles(1);
    checkOutput("timeout_erro", quadro_erro, 1);
    checkOutput("timeout_ocupado", ocupado, 0);
    exp_err++;
    idleCycles(3);
    checkOutput("erro_count_timeout", erro_count, exp_err);

    // Byte landing on the terminal cycle wins over the timeout
    pushExpected("010002000150");
    applyStimulus("#0");
    sendByte("1");
    idleCycles(18);
    sendByte("0");
    checkOutput("terminal_erro", quadro_erro, 0);
    checkOutput("terminal_ocupado", ocupado, 1);
    idleCycles(2);
    applyStimulus("002000150");
    sendChecksum("010002000150");
    idleCycles(3);
    checkOutput("erro_count_terminal", erro_count, exp_err);
    checkOutput("ok_count_terminal", ok_count, exp_ok);

    // Reset mid-frame discards silently
    applyStimulus("#0100");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("rstmid_ocupado", ocupado, 0);
    checkOutput("rstmid_ok", quadro_ok, 0);
    checkOutput("rstmid_erro", quadro_erro, 0);
    checkOutput("rstmid_peso_atual", peso_atual, 0);
    idleCycles(25);
    checkOutput("erro_count_rstmid", erro_count, exp_err);
    sendFrame("010005000250");
    checkOutput("ok_count_rstmid", ok_count, exp_ok);

`ifdef ANALISADOR_CHECKSUM_EN
    // Wrong XOR byte aborts the frame
    applyStimulus("#010005000250");
    sendByte(xorOf("010005000250") ^ 8'h01);
    exp_err++;
    idleCycles(4);
    checkOutput("erro_count_xor", erro_count, exp_err);
    checkOutput("ok_count_xor", ok_count, exp_ok);
`endif

    idleCycles(5);
    checkOutput("sb_pendente", sb.size(), 0);
    checkOutput("ok_count_final", ok_count, exp_ok);
    checkOutput("erro_count_final", erro_count, exp_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/analisador_quadro_peso.md
Name: analisador_quadro_peso

Overview:
Parametrised frame parser and range checker for the weighing station. It consumes bytes from the serial receiver's valid/byte interface and accepts a frame: '#', then min, max and current weight as ASCII decimal digits. Completed frames are latched as packed BCD and compared against the interval. It replaces the fixed 56-bit shift-register scheme with framing, digit validation, resync, inter-byte timeout and atomic field update.

Parameters:
DIGITS, 4, decimal digits per field; field width W = 4*DIGITS bits.
TIMEOUT_CYCLES, 5_000_000, idle clock cycles allowed between bytes inside a frame.
TW, 23, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
clock  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
rx_valid  in  1  one-cycle strobe: rx_byte is valid.
rx_byte  in  8  received ASCII byte.
peso_min  out  W  latched minimum, packed BCD, MS digit first.
peso_max  out  W  latched maximum, packed BCD.
peso_atual  out  W  latched current weight, packed BCD.
pertence_intervalo  out  1  registered: peso_min <= peso_atual <= peso_max.
peso_max_zero  out  1  registered: peso_max == 0.
quadro_ok  out  1  one-cycle pulse: frame accepted and outputs updated.
quadro_erro  out  1  one-cycle pulse: frame aborted.
ocupado  out  1  high while in any state other than ESPERA.

Behaviour:
- Reset: all outputs 0, state ESPERA, shadow registers and counters cleared. Reset mid-frame discards the partial frame with no error pulse.
- States: ESPERA, CAMPO_MIN, CAMPO_MAX, CAMPO_ATUAL, FIM (and CHECK when the optional feature is enabled).
- ESPERA: ignore every byte except '#' (8'h23). On '#', clear the digit counter and go to CAMPO_MIN.
- CAMPO_*: each rx_valid with byte in '0'..'9' shifts (byte - 8'h30)[3:0] into the field's shadow register from the LS nibble. After DIGITS digits, advance to the next field.
- Last digit of CAMPO_ATUAL goes to FIM.
- FIM lasts one cycle. peso_min/max/atual are copied from the shadow registers, quadro_ok pulses, and state returns to ESPERA. quadro_ok rises on the edge after the last digit's rx_valid.
- pertence_intervalo and peso_max_zero are registered from the latched fields. They are valid one cycle after quadro_ok.
- Comparison: unsigned compare of packed BCD, which is valid because all nibbles are 0-9.
- If min > max, pertence_intervalo = 0.
- Outputs change only in FIM; an aborted frame leaves the previous values intact.
- Non-digit byte other than '#' inside a field: quadro_erro pulse, go to ESPERA.
- '#' inside a frame: resync. Clear the shadow registers and digit counter, go to CAMPO_MIN, and raise no error.
- Timeout: the counter clears on every rx_valid and counts while ocupado with no rx_valid. At TIMEOUT_CYCLES-1: quadro_erro pulse, go to ESPERA.
- Timeout terminal and rx_valid in the same cycle: the byte wins and no timeout occurs.
- At most one of quadro_ok / quadro_erro is asserted per cycle.
- rx_valid is ignored in the FIM cycle; the serial receiver guarantees byte spacing far above 1 cycle.

Optional Feature:
ANALISADOR_CHECKSUM_EN.
- Defined: after the last CAMPO_ATUAL digit, go to CHECK. The next byte must equal the XOR of all 3*DIGITS received ASCII digit bytes. A match goes to FIM. A mismatch gives a quadro_erro pulse and ESPERA. '#' in CHECK resyncs as above, and the timeout also applies in CHECK.
- Undefined: the CHECK state and XOR accumulator are absent, and behaviour is exactly as above.

Decomposition:
- Shared include/package: ASCII constants (ASCII_HASH 8'h23, ASCII_ZERO 8'h30, ASCII_NINE 8'h39) and the state encoding localparams.
- One sub-module: contador_timeout_quadro (parameters TIMEOUT_CYCLES, TW; inputs clock, reset, zera, conta; output fim). It is reusable by later protocol blocks.

Test Plan:
- DIGITS=4, bytes "#010005000250" -> quadro_ok once; peso_min=16'h0100, peso_max=16'h0500, peso_atual=16'h0250; next cycle pertence_intervalo=1, peso_max_zero=0.
- Boundaries: "#010005000500" and "#010005000100" -> pertence_intervalo=1; "#010005000501" -> 0; "#050001000300" (min>max) -> 0; "#000000000000" -> peso_max_zero=1.
- "#0100A" -> quadro_erro pulse, ESPERA; peso_* keep the prior frame's values; no quadro_ok.
- "#0100050" then "#010002000150" -> single quadro_ok, fields 0100/0200/0150, no quadro_erro.
- TIMEOUT_CYCLES=20: "#01" then 20 idle cycles -> quadro_erro on the 20th idle cycle; a byte arriving exactly at the terminal cycle -> no error.
- reset asserted after "#0100" -> ocupado=0 next cycle, no pulses; the following full frame parses correctly. With ANALISADOR_CHECKSUM_EN: a correct XOR byte -> quadro_ok; a wrong XOR byte -> quadro_erro.
